// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle sequencer for the 16-bit MIPS datapath
//
// Purpose:
//   Steps each instruction through fetch / decode / execute / memory /
//   writeback, drives every datapath enable and mux select, handshakes with
//   the shared instruction/data memory port and counts retired instructions.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   opcode                instruction[15:13] from the IR
//   zero                  ALU zero flag (branch decision)
//   mem_ready             memory completes the current request this cycle
//   mem_req/mem_we/iord   memory request, write strobe, address select
//   ir_write/pc_write     IR and PC load enables
//   pc_src                PC source: ALU result / ALUOut / jump target
//   alu_src_a/alu_src_b   ALU operand selects
//   alu_op                add / sub / use funct
//   reg_write/reg_dst     register-file write enable and destination select
//   mem_to_reg            writeback source: ALUOut or MDR
//   halted                core halted (sticky until reset)
//   retired               retired-instruction count, wraps modulo 2^RETIRE_W
//   state_dbg             current state encoding
module mc_control_unit #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state_dbg
);

  typedef enum logic [3:0] {
    RESET_S   = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXEC_R    = 4'd3,
    WB_R      = 4'd4,
    EXEC_ADDR = 4'd5,
    WB_I      = 4'd6,
    MEM_RD    = 4'd7,
    WB_MEM    = 4'd8,
    MEM_WR    = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    HALT_S    = 4'd12
  } state_e;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_J    = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [RETIRE_W-1:0] RETIRE_ONE = RETIRE_W'(1);

  state_e                state_q, state_d;
  logic [2:0]            opcode_q;
  logic [RETIRE_W-1:0]   retired_q, retired_d;
  logic                  retire_inc;

  // State register. The opcode is captured while in DECODE so that the
  // EXEC_ADDR fan-out is immune to the IR changing underneath it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_S;
      opcode_q  <= 3'b000;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      if (state_q == DECODE) begin
        opcode_q <= opcode;
      end
    end
  end

  // Next-state and retire decision.
  always_comb begin
    state_d    = state_q;
    retire_inc = 1'b0;
    case (state_q)
      RESET_S: state_d = FETCH;
      FETCH: begin
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        // Live opcode here: this is the same edge that captures opcode_q.
        case (opcode)
          OP_R:                   state_d = EXEC_R;
          OP_ADDI, OP_LW, OP_SW:  state_d = EXEC_ADDR;
          OP_BEQ:                 state_d = BRANCH;
          OP_J:                   state_d = JUMP;
          OP_NOP: begin
            state_d    = FETCH;
            retire_inc = 1'b1;
          end
          OP_HALT:                state_d = HALT_S;
          default:                state_d = FETCH;
        endcase
      end
      EXEC_R: state_d = WB_R;
      WB_R: begin
        state_d    = FETCH;
        retire_inc = 1'b1;
      end
      EXEC_ADDR: begin
        case (opcode_q)
          OP_ADDI: state_d = WB_I;
          OP_LW:   state_d = MEM_RD;
          OP_SW:   state_d = MEM_WR;
          default: state_d = FETCH;
        endcase
      end
      WB_I: begin
        state_d    = FETCH;
        retire_inc = 1'b1;
      end
      MEM_RD: begin
        if (mem_ready) state_d = WB_MEM;
      end
      WB_MEM: begin
        state_d    = FETCH;
        retire_inc = 1'b1;
      end
      MEM_WR: begin
        if (mem_ready) begin
          state_d    = FETCH;
          retire_inc = 1'b1;
        end
      end
      BRANCH: begin
        state_d    = FETCH;
        retire_inc = 1'b1;
      end
      JUMP: begin
        state_d    = FETCH;
        retire_inc = 1'b1;
      end
      HALT_S:  state_d = HALT_S;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (retire_inc) retired_d = retired_q + RETIRE_ONE;
  end

  // Outputs are a pure decode of the current state, so an asynchronous reset
  // drops any pending request without waiting for a clock edge.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        // PC+1 is written together with the IR on the completing cycle.
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      DECODE: begin
        alu_src_b = 2'b10;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      EXEC_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      WB_I: begin
        reg_write = 1'b1;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_write  = zero;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      HALT_S: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  assign retired   = retired_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - randomized self-checking bench for mc_control_unit
module tb_mc_control_unit;

  logic        clk;
  logic        rst_n;
  logic [2:0]  opcode;
  logic        zero;
  logic        mem_ready;

  logic        mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic        alu_src_a, reg_write, reg_dst, mem_to_reg, halted;
  logic [15:0] retired;
  logic [3:0]  state_dbg;

  logic        d4_mem_req, d4_mem_we, d4_iord, d4_ir_write, d4_pc_write;
  logic [1:0]  d4_pc_src, d4_alu_src_b, d4_alu_op;
  logic        d4_alu_src_a, d4_reg_write, d4_reg_dst, d4_mem_to_reg, d4_halted;
  logic [3:0]  d4_retired;
  logic [3:0]  d4_state_dbg;

  mc_control_unit u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .halted(halted),
    .retired(retired), .state_dbg(state_dbg)
  );

  mc_control_unit #(.RETIRE_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(d4_mem_req), .mem_we(d4_mem_we), .iord(d4_iord), .ir_write(d4_ir_write),
    .pc_write(d4_pc_write), .pc_src(d4_pc_src), .alu_src_a(d4_alu_src_a),
    .alu_src_b(d4_alu_src_b), .alu_op(d4_alu_op), .reg_write(d4_reg_write),
    .reg_dst(d4_reg_dst), .mem_to_reg(d4_mem_to_reg), .halted(d4_halted),
    .retired(d4_retired), .state_dbg(d4_state_dbg)
  );

  logic [15:0] outs, d4_outs;
  assign outs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                 alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, halted};
  assign d4_outs = {d4_mem_req, d4_mem_we, d4_iord, d4_ir_write, d4_pc_write, d4_pc_src,
                    d4_alu_src_a, d4_alu_src_b, d4_alu_op, d4_reg_write, d4_reg_dst,
                    d4_mem_to_reg, d4_halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] model_cnt;  // instructions retired since last reset

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Control word the datapath should see in a given state.
  function automatic logic [15:0] exp_outs(int st, bit mr, bit z);
    logic mreq = 0, we = 0, io = 0, irw = 0, pcw = 0, asa = 0;
    logic rw = 0, rd = 0, m2r = 0, h = 0;
    logic [1:0] ps = 0, asb = 0, aop = 0;
    case (st)
      1:  begin mreq = 1; asb = 2'b01; if (mr) begin irw = 1; pcw = 1; end end
      2:  asb = 2'b10;
      3:  begin asa = 1; aop = 2'b10; end
      4:  begin rw = 1; rd = 1; end
      5:  begin asa = 1; asb = 2'b10; end
      6:  rw = 1;
      7:  begin mreq = 1; io = 1; end
      8:  begin rw = 1; m2r = 1; end
      9:  begin mreq = 1; io = 1; we = 1; end
      10: begin asa = 1; aop = 2'b01; ps = 2'b01; pcw = z; end
      11: begin pcw = 1; ps = 2'b10; end
      12: h = 1;
      default: ;
    endcase
    return {mreq, we, io, irw, pcw, ps, asa, asb, aop, rw, rd, m2r, h};
  endfunction

  // One clock cycle: drive inputs after the falling edge, check outputs.
  task automatic cycle(input int st, input bit mr, input bit z, input logic [2:0] op);
    @(negedge clk);
    mem_ready = mr;
    zero      = z;
    opcode    = op;
    #1;
    check($sformatf("state st%0d", st), 32'(state_dbg), 32'(st));
    check($sformatf("outs st%0d", st), 32'(outs), 32'(exp_outs(st, mr, z)));
    check($sformatf("w4 state st%0d", st), 32'(d4_state_dbg), 32'(st));
    check($sformatf("w4 outs st%0d", st), 32'(d4_outs), 32'(exp_outs(st, mr, z)));
  endtask

  task automatic check_retired(input string tag);
    check({tag, " retired"}, 32'(retired), 32'(model_cnt));
    check({tag, " retired w4"}, 32'(d4_retired), 32'(model_cnt[3:0]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    model_cnt = '0;
    #1;
    check("reset state", 32'(state_dbg), 32'd0);
    check("reset outs", 32'(outs), 32'd0);
    check_retired("reset");
    rst_n = 1'b1;
    #1;
    check("post-release state", 32'(state_dbg), 32'd0);
  endtask

  // Execute one instruction. Its state trace is derived from the
  // instruction class: fetch waits, then the per-opcode path, with
  // mem_ready held low for the requested number of cycles in memory states.
  task automatic run_instr(input logic [2:0] op, input int fw, input int mw, input bit zb);
    int  sts[$];
    bit  mrs[$];
    for (int i = 0; i < fw; i++) begin sts.push_back(1); mrs.push_back(0); end
    sts.push_back(1); mrs.push_back(1);
    sts.push_back(2); mrs.push_back(1'($urandom));
    case (op)
      3'd0: begin sts.push_back(3); sts.push_back(4); repeat (2) mrs.push_back(1'($urandom)); end
      3'd1: begin sts.push_back(5); sts.push_back(6); repeat (2) mrs.push_back(1'($urandom)); end
      3'd2: begin
        sts.push_back(5); mrs.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin sts.push_back(7); mrs.push_back(0); end
        sts.push_back(7); mrs.push_back(1);
        sts.push_back(8); mrs.push_back(1'($urandom));
      end
      3'd3: begin
        sts.push_back(5); mrs.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin sts.push_back(9); mrs.push_back(0); end
        sts.push_back(9); mrs.push_back(1);
      end
      3'd4: begin sts.push_back(10); mrs.push_back(1'($urandom)); end
      3'd5: begin sts.push_back(11); mrs.push_back(1'($urandom)); end
      3'd7: for (int i = 0; i < 20; i++) begin sts.push_back(12); mrs.push_back(1'($urandom)); end
      default: ;
    endcase
    for (int i = 0; i < sts.size(); i++) begin
      // After DECODE the IR contents are junk as far as the sequencer cares.
      cycle(sts[i], mrs[i], (sts[i] == 10) ? zb : 1'($urandom),
            (sts[i] <= 2) ? op : 3'($urandom));
    end
    if (op != 3'd7) model_cnt = model_cnt + 16'd1;
    @(posedge clk);
    #1;
    check_retired($sformatf("op%0d", op));
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 3'b000;
    zero = 1'b0;
    mem_ready = 1'b0;
    model_cnt = '0;

    do_reset();
    run_instr(3'd0, 0, 0, 0);          // R-type, zero-wait
    run_instr(3'd2, 0, 3, 0);          // lw with three wait cycles
    run_instr(3'd4, 0, 0, 1);          // beq taken
    run_instr(3'd4, 0, 0, 0);          // beq not taken
    run_instr(3'd3, 0, 0, 0);          // sw
    run_instr(3'd5, 0, 0, 0);          // j
    run_instr(3'd6, 0, 0, 0);          // nop
    run_instr(3'd1, 2, 0, 0);          // addi with fetch waits

    // Counter wrap on the 4-bit instance.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      run_instr(3'd6, 0, 0, 0);
      if (i == 15) check("wrap15", 32'(d4_retired), 32'd15);
      if (i == 16) check("wrap16", 32'(d4_retired), 32'd0);
      if (i == 17) check("wrap17", 32'(d4_retired), 32'd1);
    end

    // Random instruction mix (no halt).
    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 6));
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    // Halt is sticky and does not retire.
    run_instr(3'd7, 1, 0, 0);

    // Asynchronous reset while a load waits on memory.
    do_reset();
    cycle(1, 1, 0, 3'd2);
    cycle(2, 0, 0, 3'd2);
    cycle(5, 0, 0, 3'd0);
    cycle(7, 0, 0, 3'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async mem_req", 32'(mem_req), 32'd0);
    check("async state", 32'(state_dbg), 32'd0);
    check("async retired", 32'(retired), 32'd0);
    check("async w4 mem_req", 32'(d4_mem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle sequencer for the 16-bit MIPS datapath (fetch / decode / execute / memory / writeback).
- Consumes the 3-bit opcode produced by the decode stage (instruction[15:13]) and the ALU zero flag.
- Drives all datapath enables and mux selects, and handshakes with a shared instruction/data memory port.
- Counts retired instructions for debug.

Parameters:
RETIRE_W, 16, width of retired-instruction counter (wraps modulo 2^RETIRE_W)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  3  instruction[15:13] from IR
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current request this cycle
mem_req  output  1  memory request valid
mem_we  output  1  1 = write, 0 = read (valid with mem_req)
iord  output  1  address select: 0 = PC, 1 = ALUOut
ir_write  output  1  load IR
pc_write  output  1  load PC
pc_src  output  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
alu_src_a  output  1  0 = PC, 1 = readData1
alu_src_b  output  2  00 = readData2, 01 = constant 1, 10 = signExtend
alu_op  output  2  00 = add, 01 = sub, 10 = use funct
reg_write  output  1  register-file write enable
reg_dst  output  1  0 = rt, 1 = rd
mem_to_reg  output  1  0 = ALUOut, 1 = MDR
halted  output  1  core halted
retired  output  RETIRE_W  retired-instruction count
state_dbg  output  4  current state encoding

Behaviour:
- Reset: async on rst_n low. State = RESET_S (0), retired = 0, every output 0, including any pending mem_req, which is dropped immediately. First clock edge after release moves to FETCH.
- Outputs are decoded from state. ir_write and pc_write also depend on mem_ready / zero as listed below. Any output not listed for a state is 0.
- Opcode map: 000 R-type, 001 addi, 010 lw, 011 sw, 100 beq, 101 j, 110 nop, 111 halt.
- The opcode is latched into an internal register on the DECODE cycle. EXEC_ADDR branching uses the latched value, so a changing IR has no effect.
- States (encoding, asserted outputs, next state):
  - FETCH (1): mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. While mem_ready=0, hold. When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, next DECODE.
  - DECODE (2): alu_src_a=0, alu_src_b=10, alu_op=00 (precompute branch target). Next by opcode: 000 EXEC_R; 001/010/011 EXEC_ADDR; 100 BRANCH; 101 JUMP; 110 FETCH (nop retires here); 111 HALT.
  - EXEC_R (3): alu_src_a=1, alu_src_b=00, alu_op=10. Next WB_R.
  - WB_R (4): reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
  - EXEC_ADDR (5): alu_src_a=1, alu_src_b=10, alu_op=00. Next: 001 WB_I, 010 MEM_RD, 011 MEM_WR.
  - WB_I (6): reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
  - MEM_RD (7): mem_req=1, iord=1, mem_we=0. Hold until mem_ready, then WB_MEM.
  - WB_MEM (8): reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
  - MEM_WR (9): mem_req=1, iord=1, mem_we=1. Hold until mem_ready, then FETCH.
  - BRANCH (10): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=zero. Next FETCH.
  - JUMP (11): pc_write=1, pc_src=10. Next FETCH.
  - HALT (12): halted=1, all else 0. Stays in HALT until reset; mem_ready is ignored.
  - Unused encodings (13–15): next state FETCH, outputs 0.
- Handshake:
  - mem_req, mem_we and iord stay stable from assertion until the cycle in which mem_ready=1.
  - mem_ready seen outside FETCH, MEM_RD or MEM_WR is ignored.
  - A request completes in a single cycle when mem_ready is already high on the cycle mem_req rises.
- Retire counter:
  - Increments by 1 on the clock edge leaving WB_R, WB_I, WB_MEM, BRANCH or JUMP.
  - Increments on the edge leaving MEM_WR with mem_ready=1, and on the edge leaving DECODE with a nop.
  - halt does not count.
  - Wraps from all-ones to 0.
- Latency with zero-wait memory (cycles, FETCH through last state): R 4, addi 4, lw 5, sw 4, beq 3, j 3, nop 2. Each wait cycle on mem_ready adds 1.

Test Plan:
- Reset and fetch: hold rst_n=0, then release; mem_ready=1; opcode=000 -> state_dbg sequence 0,1,2,3,4,1; reg_write=1 and reg_dst=1 only in state 4; retired=1 after WB_R.
- lw with wait states: opcode=010, mem_ready low 3 cycles in MEM_RD -> mem_req=1, iord=1, mem_we=0 held 4 cycles; WB_MEM asserts mem_to_reg=1; total 8 cycles; retired +1.
- beq both ways: opcode=100, zero=1 -> pc_write=1, pc_src=01 in BRANCH. Repeat with zero=0 -> pc_write=0. Both cases retired +1 and next state FETCH.
- sw, j, nop: opcode=011 -> MEM_WR with mem_we=1 then FETCH. Opcode=101 -> pc_src=10, pc_write=1. Opcode=110 -> DECODE to FETCH, retired +1.
- Halt and async reset: opcode=111 -> halted=1 held for 20 cycles with no mem_req. Separately, pull rst_n low mid-MEM_RD (mem_ready=0) -> mem_req drops to 0 with no clock edge; state_dbg=0; retired=0.
- Counter wrap: RETIRE_W=4, run 17 nops -> retired reads 15 after 15 nops, 0 after the 16th, 1 after the 17th.
